mem_wb_stage: RTL and testbench

s; they produce WB_EN=0.
REQ-013 SHALL ignore memory_out whenever MEM_R_EN_in=0 or mem_ready=0.

Reset
REQ-014 SHALL, on rst=1, asynchronously clear: pc=0, WB_EN=0, MEM_R_EN=0, Dest=0, ALU_Res=0, load data=0, stall_count=0, FSM=IDLE; WB_Value therefore 0.
REQ-015 SHALL drive freeze from inputs during reset; no register updates while rst=1.
REQ-016 SHALL discard an in-progress stall on reset mid-WAIT; first post-reset capture follows REQ-006.

Structure
REQ-017 SHALL take ADDRESS_LEN, WORD_LEN, REG_ADDR_LEN defaults and FSM state encodings (IDLE=0, WAIT=1) from the shared configs include.
REQ-018 SHALL instantiate one sub-module, wb_mux, for the REQ-004 selection; the register, FSM and counter remain in mem_wb_stage.

Verification
REQ-019 ALU op: WB_EN_in=1, Dest_in=3, ALU_Res_in=0x10, MEM_R_EN_in=0, mem_ready=1 -> next cycle WB_EN=1, WB_Dest=3, WB_Value=0x10, freeze=0.
REQ-020 Load, 3-cycle miss: MEM_R_EN_in=1, Dest_in=5, mem_ready=0 for 3 cycles then 1 with memory_out=0xDEADBEEF -> freeze=1 for 3 cycles, WB_EN=0 during them, then exactly one cycle WB_EN=1, WB_Value=0xDEADBEEF, stall_count=3.
REQ-021 Store, 2-cycle stall: MEM_W_EN_in=1, WB_EN_in=0, mem_ready=0 for 2 cycles -> freeze=1 for 2 cycles, WB_EN never 1, stall_count +=2.
REQ-022 Reset mid-stall: load stalling 2 cycles, rst pulsed -> all outputs 0, FSM IDLE, stall_count=0 immediately, without a clock edge.
REQ-023 Counter wrap: stall_count preloaded to 0xFFFFFFFF via stimulus (forced), one stall cycle -> stall_count=0.
REQ-024 Back-to-back loads, each hit (mem_ready=1): memory_out 0x1, 0x2 -> WB_Value 0

---
 rtl/mem_wb_stage_pkg.sv | 22 ++
 rtl/mem_wb_stage_wb_mux.sv | 21 ++
 rtl/mem_wb_stage.sv | 104 ++++++++++
 tb/tb_mem_wb_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage_pkg
//  Brief    : Shared widths, FSM encodings and helpers for the MEM/WB stage.
//  Revision : 1.0
// ============================================================================
package mem_wb_stage_pkg;

    localparam int unsigned C_ADDRESS_LEN  = 32;
    localparam int unsigned C_WORD_LEN     = 32;
    localparam int unsigned C_REG_ADDR_LEN = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // A memory access that has not completed must hold the whole pipeline.
    function automatic logic f_freeze(input logic i_rd, input logic i_wr, input logic i_ready);
        return (i_rd | i_wr) & ~i_ready;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_wb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : wb_mux
//  Brief    : Write-back data select between load data and ALU result.
//  Revision : 1.0
// ============================================================================
module wb_mux
    import mem_wb_stage_pkg::*;
#(
    parameter int WORD_LEN = C_WORD_LEN
) (
    input  logic                i_mem_r_en,
    input  logic [WORD_LEN-1:0] i_alu_res,
    input  logic [WORD_LEN-1:0] i_load_data,
    output logic [WORD_LEN-1:0] o_value
);

    assign o_value = i_mem_r_en ? i_load_data : i_alu_res;

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage
//  Brief    : MEM/WB pipeline register with memory-stall freeze and counter.
//  Revision : 1.0
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int ADDRESS_LEN  = C_ADDRESS_LEN,
    parameter int WORD_LEN     = C_WORD_LEN,
    parameter int REG_ADDR_LEN = C_REG_ADDR_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDRESS_LEN-1:0]  pc_in,
    input  logic                    WB_EN_in,
    input  logic                    MEM_R_EN_in,
    input  logic                    MEM_W_EN_in,
    input  logic [REG_ADDR_LEN-1:0] Dest_in,
    input  logic [WORD_LEN-1:0]     ALU_Res_in,
    input  logic [WORD_LEN-1:0]     memory_out,
    input  logic                    mem_ready,
    output logic [ADDRESS_LEN-1:0]  pc,
    output logic                    WB_EN,
    output logic [REG_ADDR_LEN-1:0] WB_Dest,
    output logic [WORD_LEN-1:0]     WB_Value,
    output logic                    freeze,
    output logic [31:0]             stall_count
);

    logic [ADDRESS_LEN-1:0]  r_pc;
    logic                    r_wb_en;
    logic                    r_mem_r_en;
    logic [REG_ADDR_LEN-1:0] r_dest;
    logic [WORD_LEN-1:0]     r_alu_res;
    logic [WORD_LEN-1:0]     r_load_data;
    logic [31:0]             r_stall_count;
    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic                    w_freeze;

    assign w_freeze = f_freeze(MEM_R_EN_in, MEM_W_EN_in, mem_ready);

    // A frozen edge inserts a bubble so a stalled instruction writes back once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= '0;
            r_wb_en     <= 1'b0;
            r_mem_r_en  <= 1'b0;
            r_dest      <= '0;
            r_alu_res   <= '0;
            r_load_data <= '0;
        end else if (w_freeze) begin
            r_wb_en     <= 1'b0;
            r_mem_r_en  <= 1'b0;
        end else begin
            r_pc        <= pc_in;
            r_wb_en     <= WB_EN_in;
            r_mem_r_en  <= MEM_R_EN_in;
            r_dest      <= Dest_in;
            r_alu_res   <= ALU_Res_in;
            r_load_data <= memory_out;
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: w_state_nxt = w_freeze ? ST_WAIT : ST_IDLE;
            ST_WAIT: w_state_nxt = w_freeze ? ST_WAIT : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_freeze) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    wb_mux #(
        .WORD_LEN (WORD_LEN)
    ) u_wb_mux (
        .i_mem_r_en  (r_mem_r_en),
        .i_alu_res   (r_alu_res),
        .i_load_data (r_load_data),
        .o_value     (WB_Value)
    );

    assign pc          = r_pc;
    assign WB_EN       = r_wb_en;
    assign WB_Dest     = r_dest;
    assign freeze      = w_freeze;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_stage
//  Brief    : Directed, table-driven checks of the MEM/WB stage.
//  Revision : 1.0
// ============================================================================
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        WB_EN_in;
    logic        MEM_R_EN_in;
    logic        MEM_W_EN_in;
    logic [3:0]  Dest_in;
    logic [31:0] ALU_Res_in;
    logic [31:0] memory_out;
    logic        mem_ready;
    logic [31:0] pc;
    logic        WB_EN;
    logic [3:0]  WB_Dest;
    logic [31:0] WB_Value;
    logic        freeze;
    logic [31:0] stall_count;

    int n_vec = 0;
    int n_err = 0;

    mem_wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .WB_EN_in    (WB_EN_in),
        .MEM_R_EN_in (MEM_R_EN_in),
        .MEM_W_EN_in (MEM_W_EN_in),
        .Dest_in     (Dest_in),
        .ALU_Res_in  (ALU_Res_in),
        .memory_out  (memory_out),
        .mem_ready   (mem_ready),
        .pc          (pc),
        .WB_EN       (WB_EN),
        .WB_Dest     (WB_Dest),
        .WB_Value    (WB_Value),
        .freeze      (freeze),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        wb_en;
        logic        mr;
        logic        mw;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] mo;
        logic        e_wb_en;
        logic [31:0] e_value;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] p, input logic we, input logic mr, input logic mw,
                         input logic [3:0] d, input logic [31:0] alu, input logic [31:0] mo,
                         input logic rdy);
        pc_in = p; WB_EN_in = we; MEM_R_EN_in = mr; MEM_W_EN_in = mw;
        Dest_in = d; ALU_Res_in = alu; memory_out = mo; mem_ready = rdy;
    endtask

    task automatic edge_then_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{32'h100, 1'b1, 1'b0, 1'b0, 4'd3,  32'h10,       32'h5555,     1'b1, 32'h10};
        tbl[1] = '{32'h104, 1'b1, 1'b1, 1'b0, 4'd7,  32'h2000,     32'h1,        1'b1, 32'h1};
        tbl[2] = '{32'h108, 1'b1, 1'b1, 1'b0, 4'd8,  32'h2004,     32'h2,        1'b1, 32'h2};
        tbl[3] = '{32'h10c, 1'b0, 1'b0, 1'b1, 4'd0,  32'h3000,     32'hAAAA,     1'b0, 32'h3000};
        tbl[4] = '{32'h110, 1'b0, 1'b0, 1'b0, 4'd9,  32'h77,       32'hBBBB,     1'b0, 32'h77};
        tbl[5] = '{32'h114, 1'b1, 1'b0, 1'b0, 4'd15, 32'hFFFFFFFF, 32'h1234,     1'b1, 32'hFFFFFFFF};

        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
        #12;
        chk("reset_pc", pc, 32'h0);
        chk("reset_wb_en", {31'b0, WB_EN}, 32'h0);
        chk("reset_value", WB_Value, 32'h0);
        chk("reset_stall", stall_count, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle hits: no freeze, result visible after one edge.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(tbl[i].pc, tbl[i].wb_en, tbl[i].mr, tbl[i].mw, tbl[i].dest,
                  tbl[i].alu, tbl[i].mo, 1'b1);
            #1;
            chk($sformatf("v%0d_freeze", i), {31'b0, freeze}, 32'h0);
            edge_then_sample();
            chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
            chk($sformatf("v%0d_wb_en", i), {31'b0, WB_EN}, {31'b0, tbl[i].e_wb_en});
            chk($sformatf("v%0d_dest", i), {28'b0, WB_Dest}, {28'b0, tbl[i].dest});
            chk($sformatf("v%0d_value", i), WB_Value, tbl[i].e_value);
        end
        chk("hits_no_stall", stall_count, 32'h0);

        // Load, 3-cycle miss.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(32'h200, 1'b1, 1'b1, 1'b0, 4'd5, 32'h4000, 32'h0, 1'b0);
            #1;
            chk($sformatf("ldmiss_freeze%0d", c), {31'b0, freeze}, 32'h1);
            edge_then_sample();
            chk($sformatf("ldmiss_wb_en%0d", c), {31'b0, WB_EN}, 32'h0);
        end
        @(negedge clk);
        drive(32'h200, 1'b1, 1'b1, 1'b0, 4'd5, 32'h4000, 32'hDEADBEEF, 1'b1);
        #1;
        chk("ldmiss_freeze_done", {31'b0, freeze}, 32'h0);
        edge_then_sample();
        chk("ldmiss_wb_en", {31'b0, WB_EN}, 32'h1);
        chk("ldmiss_dest", {28'b0, WB_Dest}, 32'h5);
        chk("ldmiss_value", WB_Value, 32'hDEADBEEF);
        chk("ldmiss_stall", stall_count, 32'd3);
        @(negedge clk);
        drive(32'h204, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
        edge_then_sample();
        chk("ldmiss_once", {31'b0, WB_EN}, 32'h0);

        // Store, 2-cycle stall.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(32'h300, 1'b0, 1'b0, 1'b1, 4'd2, 32'h5000, 32'h0, 1'b0);
            #1;
            chk($sformatf("st_freeze%0d", c), {31'b0, freeze}, 32'h1);
            edge_then_sample();
            chk($sformatf("st_wb_en%0d", c), {31'b0, WB_EN}, 32'h0);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        edge_then_sample();
        chk("st_wb_en_done", {31'b0, WB_EN}, 32'h0);
        chk("st_pc", pc, 32'h300);
        chk("st_stall", stall_count, 32'd5);

        // Flush: memory request withdrawn mid-stall, ALU op taken normally.
        @(negedge clk);
        drive(32'h400, 1'b1, 1'b1, 1'b0, 4'd6, 32'h0, 32'h0, 1'b0);
        edge_then_sample();
        @(negedge clk);
        drive(32'h404, 1'b1, 1'b0, 1'b0, 4'd4, 32'h99, 32'h1111, 1'b0);
        #1;
        chk("flush_freeze", {31'b0, freeze}, 32'h0);
        edge_then_sample();
        chk("flush_wb_en", {31'b0, WB_EN}, 32'h1);
        chk("flush_value", WB_Value, 32'h99);
        chk("flush_stall", stall_count, 32'd6);

        // Reset mid-stall clears immediately, with no clock edge.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(32'h500, 1'b1, 1'b1, 1'b0, 4'd1, 32'h0, 32'h0, 1'b0);
            edge_then_sample();
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_wb_en", {31'b0, WB_EN}, 32'h0);
        chk("rst_dest", {28'b0, WB_Dest}, 32'h0);
        chk("rst_value", WB_Value, 32'h0);
        chk("rst_stall", stall_count, 32'h0);
        chk("rst_freeze_comb", {31'b0, freeze}, 32'h1);
        chk("rst_state", {31'b0, dut.r_state}, 32'h0);
        edge_then_sample();
        chk("rst_hold_stall", stall_count, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h600, 1'b1, 1'b1, 1'b0, 4'd10, 32'h0, 32'hCAFE, 1'b1);
        edge_then_sample();
        chk("post_rst_value", WB_Value, 32'hCAFE);
        chk("post_rst_wb_en", {31'b0, WB_EN}, 32'h1);

        // Counter wrap.
        @(negedge clk);
        drive(32'h700, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
        force dut.r_stall_count = 32'hFFFFFFFF;
        #1;
        release dut.r_stall_count;
        #1;
        chk("wrap_preload", stall_count, 32'hFFFFFFFF);
        drive(32'h700, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0, 32'h0, 1'b0);
        edge_then_sample();
        chk("wrap_stall", stall_count, 32'h0);
        @(negedge clk);
        mem_ready = 1'b1;
        edge_then_sample();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
